div_sched: RTL and testbench

- Sequencing controller between the EXE stage and the two divider IP cores (signed `div_gen_signed`, unsigned `div_gen_unsigned`).
- Accepts one divide/modulo request at a time and drives the selected core's AXI-stream-style operand handshake.
- Captures the 64-bit core output ({quotient, remainder}) and holds the selected 32-bit half until EXE consumes it.
- Handles pipeline flush (exception/branch cancel) by draining in-flight core results without returning them.

---
 rtl/div_sched.sv | 198 +++++++++++++++++++
 tb/tb_div_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
// div_sched: one-at-a-time sequencer between EXE and the signed/unsigned divider cores.
// Latency: accept -> resp_valid = 1 SEND cycle (min) + core latency + 1; cache hit -> next cycle.
// Backpressure: req_ready only in IDLE; result held in DONE until resp_ready (or flush drops it).
//
// Ports:
//   clk, resetn               clock, synchronous active-low reset
//   req_*                     EXE request (valid/ready, signed, mod, src1 dividend, src2 divisor)
//   flush                     cancels the current request; its response is never returned
//   resp_*                    result to EXE (valid/ready, quotient or remainder)
//   busy                      scheduler not in IDLE
//   s_* / u_*                 signed / unsigned core: operand tvalid/tready, dout valid/data
//   core_dividend/divisor     operand tdata shared by both cores, stable while tvalid is high
//
// Optional build macro: DIV_SCHED_REUSE_EN adds a one-entry result cache so that a
// div followed by a mod (or vice versa) on identical operands skips the core.

module div_sched #(
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_signed,
   input  logic            req_mod,
   input  logic [DW-1:0]   req_src1,
   input  logic [DW-1:0]   req_src2,
   input  logic            flush,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [DW-1:0]   resp_result,
   output logic            busy,
   output logic            s_tvalid,
   input  logic            s_tready,
   input  logic            s_dout_valid,
   input  logic [2*DW-1:0] s_dout,
   output logic            u_tvalid,
   input  logic            u_tready,
   input  logic            u_dout_valid,
   input  logic [2*DW-1:0] u_dout,
   output logic [DW-1:0]   core_dividend,
   output logic [DW-1:0]   core_divisor
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SEND  = 3'd1;
   localparam logic [2:0] WAIT  = 3'd2;
   localparam logic [2:0] DRAIN = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   logic [2:0]      state_q,  state_d;
   logic [DW-1:0]   src1_q,   src1_d;
   logic [DW-1:0]   src2_q,   src2_d;
   logic            signed_q, signed_d;
   logic            mod_q,    mod_d;
   logic            cancel_q, cancel_d;
   logic [2*DW-1:0] res64_q,  res64_d;

`ifdef DIV_SCHED_REUSE_EN
   logic            c_vld_q,    c_vld_d;
   logic            c_signed_q, c_signed_d;
   logic [DW-1:0]   c_src1_q,   c_src1_d;
   logic [DW-1:0]   c_src2_q,   c_src2_d;
   logic [2*DW-1:0] c_res64_q,  c_res64_d;
   logic            cache_hit;

   // Operation type (req_mod) is deliberately not part of the key: both halves
   // of the core output are kept, so either one can be served from the entry.
   assign cache_hit = c_vld_q && (c_signed_q == req_signed) &&
                      (c_src1_q == req_src1) && (c_src2_q == req_src2);
`endif

   // Everything after acceptance follows the core chosen at accept time only;
   // the other core's handshake and dout are never looked at.
   logic            sel_tready;
   logic            sel_dout_valid;
   logic [2*DW-1:0] sel_dout;

   assign sel_tready     = signed_q ? s_tready     : u_tready;
   assign sel_dout_valid = signed_q ? s_dout_valid : u_dout_valid;
   assign sel_dout       = signed_q ? s_dout       : u_dout;

   assign req_ready     = (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   assign resp_valid    = (state_q == DONE);
   assign s_tvalid      = (state_q == SEND) &&  signed_q;
   assign u_tvalid      = (state_q == SEND) && !signed_q;
   assign core_dividend = src1_q;
   assign core_divisor  = src2_q;
   // res64_q is cleared at reset and only loaded on entry to DONE, so the mux alone
   // gives 0 out of reset and a stable value while resp_ready is low.
   assign resp_result   = mod_q ? res64_q[DW-1:0] : res64_q[2*DW-1:DW];

   always_comb begin
      state_d  = state_q;
      src1_d   = src1_q;
      src2_d   = src2_q;
      signed_d = signed_q;
      mod_d    = mod_q;
      cancel_d = cancel_q;
      res64_d  = res64_q;
`ifdef DIV_SCHED_REUSE_EN
      c_vld_d    = c_vld_q;
      c_signed_d = c_signed_q;
      c_src1_d   = c_src1_q;
      c_src2_d   = c_src2_q;
      c_res64_d  = c_res64_q;
`endif
      case (state_q)
         IDLE: begin
            // A request presented together with flush belongs to the cancelled
            // instruction and is dropped.
            if (req_valid && !flush) begin
               src1_d   = req_src1;
               src2_d   = req_src2;
               signed_d = req_signed;
               mod_d    = req_mod;
`ifdef DIV_SCHED_REUSE_EN
               if (cache_hit) begin
                  res64_d = c_res64_q;
                  state_d = DONE;
               end else begin
                  state_d = SEND;
               end
`else
               state_d = SEND;
`endif
            end
         end
         SEND: begin
            // tvalid cannot be withdrawn once raised, so a flush here only marks
            // the request; the core still gets it and its output is drained.
            if (flush) cancel_d = 1'b1;
            if (sel_tready) state_d = (cancel_q || flush) ? DRAIN : WAIT;
         end
         WAIT: begin
            if (flush) begin
               // Output arriving in the flush cycle is already consumed from the
               // core, so there is nothing left to drain.
               state_d = sel_dout_valid ? IDLE : DRAIN;
            end else if (sel_dout_valid) begin
               res64_d = sel_dout;
               state_d = DONE;
`ifdef DIV_SCHED_REUSE_EN
               c_vld_d    = 1'b1;
               c_signed_d = signed_q;
               c_src1_d   = src1_q;
               c_src2_d   = src2_q;
               c_res64_d  = sel_dout;
`endif
            end
         end
         DRAIN: begin
            if (sel_dout_valid) state_d = IDLE;
         end
         DONE: begin
            if (flush || resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_d == IDLE) cancel_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= IDLE;
         src1_q   <= '0;
         src2_q   <= '0;
         signed_q <= 1'b0;
         mod_q    <= 1'b0;
         cancel_q <= 1'b0;
         res64_q  <= '0;
`ifdef DIV_SCHED_REUSE_EN
         c_vld_q    <= 1'b0;
         c_signed_q <= 1'b0;
         c_src1_q   <= '0;
         c_src2_q   <= '0;
         c_res64_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         src1_q   <= src1_d;
         src2_q   <= src2_d;
         signed_q <= signed_d;
         mod_q    <= mod_d;
         cancel_q <= cancel_d;
         res64_q  <= res64_d;
`ifdef DIV_SCHED_REUSE_EN
         c_vld_q    <= c_vld_d;
         c_signed_q <= c_signed_d;
         c_src1_q   <= c_src1_d;
         c_src2_q   <= c_src2_d;
         c_res64_q  <= c_res64_d;
`endif
      end
   end

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed bench for div_sched with behavioural divider cores.
// Latency: cores answer 3 cycles after their operand handshake.
// Backpressure: core tready and EXE resp_ready are driven per step.
module tb_div_sched;

`ifdef DIV_SCHED_REUSE_EN
   localparam bit REUSE = 1'b1;
`else
   localparam bit REUSE = 1'b0;
`endif
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid, req_ready, req_signed, req_mod;
   logic [31:0] req_src1, req_src2;
   logic        flush;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_result;
   logic        busy;
   logic        s_tvalid, s_tready, s_dout_valid;
   logic [63:0] s_dout;
   logic        u_tvalid, u_tready, u_dout_valid;
   logic [63:0] u_dout;
   logic [31:0] core_dividend, core_divisor;

   int n_vec = 0;
   int n_err = 0;
   int s_hs = 0, u_hs = 0, resp_cnt = 0, rv_cycles = 0;

   always #5 clk = ~clk;

   div_sched #(.DW(32)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed), .req_mod(req_mod),
      .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result), .busy(busy),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_dout_valid(s_dout_valid), .s_dout(s_dout),
      .u_tvalid(u_tvalid), .u_tready(u_tready), .u_dout_valid(u_dout_valid), .u_dout(u_dout),
      .core_dividend(core_dividend), .core_divisor(core_divisor)
   );

   // Behavioural cores: one outstanding operation, {quotient, remainder} after LAT cycles.
   logic        s_pend, u_pend;
   int          s_cnt, u_cnt;
   logic [63:0] s_res, u_res;
   logic signed [31:0] sa, sb;

   always @(posedge clk) begin
      s_dout_valid <= 1'b0;
      u_dout_valid <= 1'b0;
      if (!resetn) begin
         s_pend <= 1'b0; u_pend <= 1'b0;
         s_dout <= '0;   u_dout <= '0;
      end else begin
         sa = core_dividend;
         sb = core_divisor;
         if (s_tvalid && s_tready) begin
            s_pend <= 1'b1; s_cnt <= LAT; s_res <= {sa / sb, sa % sb}; s_hs <= s_hs + 1;
         end else if (s_pend) begin
            if (s_cnt == 1) begin s_pend <= 1'b0; s_dout_valid <= 1'b1; s_dout <= s_res; end
            else s_cnt <= s_cnt - 1;
         end
         if (u_tvalid && u_tready) begin
            u_pend <= 1'b1; u_cnt <= LAT;
            u_res <= {core_dividend / core_divisor, core_dividend % core_divisor};
            u_hs <= u_hs + 1;
         end else if (u_pend) begin
            if (u_cnt == 1) begin u_pend <= 1'b0; u_dout_valid <= 1'b1; u_dout <= u_res; end
            else u_cnt <= u_cnt - 1;
         end
         if (resp_valid && resp_ready) resp_cnt <= resp_cnt + 1;
         if (resp_valid) rv_cycles <= rv_cycles + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Presents a request and returns #1 after the edge that accepted it.
   task automatic issue(input logic sg, input logic md, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      req_valid = 1'b1; req_signed = sg; req_mod = md; req_src1 = a; req_src2 = b;
      while (!req_ready && n < 40) begin step(); n++; end
      chk("issue_ready", req_ready, 1);
      step();
      req_valid = 1'b0;
   endtask

   task automatic wait_resp();
      int n = 0;
      while (!resp_valid && n < 40) begin step(); n++; end
      chk("resp_arrives", resp_valid, 1);
   endtask

   task automatic consume();
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
   endtask

   int s0, u0, r0, v0;

   initial begin
      resetn = 1'b0; req_valid = 1'b0; req_signed = 1'b0; req_mod = 1'b0;
      req_src1 = '0; req_src2 = '0; flush = 1'b0; resp_ready = 1'b0;
      s_tready = 1'b1; u_tready = 1'b1;
      repeat (3) step();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_s_tvalid", s_tvalid, 0);
      chk("rst_u_tvalid", u_tvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result", resp_result, 0);
      resetn = 1'b1;
      step();

      // req_valid with flush in IDLE is ignored
      req_valid = 1'b1; flush = 1'b1; req_src1 = 32'd5; req_src2 = 32'd1;
      step();
      req_valid = 1'b0; flush = 1'b0;
      chk("idle_flush_busy", busy, 0);

      // signed -7 / 2
      s0 = s_hs; u0 = u_hs;
      issue(1'b1, 1'b0, 32'hFFFFFFF9, 32'd2);
      chk("sdiv_s_tvalid", s_tvalid, 1);
      chk("sdiv_u_tvalid", u_tvalid, 0);
      wait_resp();
      chk("sdiv_result", resp_result, 32'hFFFFFFFD);
      consume();
      chk("sdiv_s_hs", s_hs - s0, 1);
      chk("sdiv_u_hs", u_hs - u0, 0);

      // signed -7 % 2 (cache hit when reuse is built in)
      s0 = s_hs;
      issue(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2);
      chk("smod_fast_valid", resp_valid, REUSE);
      wait_resp();
      chk("smod_result", resp_result, 32'hFFFFFFFF);
      consume();
      chk("smod_s_hs", s_hs - s0, REUSE ? 0 : 1);
      chk("smod_u_hs", u_hs - u0, 0);

      // unsigned 0xFFFFFFF9 / 2 and % 2
      s0 = s_hs; u0 = u_hs;
      issue(1'b0, 1'b0, 32'hFFFFFFF9, 32'd2);
      chk("udiv_u_tvalid", u_tvalid, 1);
      chk("udiv_s_tvalid", s_tvalid, 0);
      wait_resp();
      chk("udiv_result", resp_result, 32'h7FFFFFFC);
      consume();
      issue(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
      wait_resp();
      chk("umod_result", resp_result, 32'h00000001);
      consume();
      chk("u_u_hs", u_hs - u0, REUSE ? 1 : 2);
      chk("u_s_hs", s_hs - s0, 0);

      // back-pressure: 100 / 7 held for 5 cycles
      r0 = resp_cnt;
      issue(1'b0, 1'b0, 32'd100, 32'd7);
      wait_resp();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", resp_valid, 1);
         chk("bp_result", resp_result, 32'h0000000E);
         step();
      end
      consume();
      chk("bp_one_resp", resp_cnt - r0, 1);
      chk("bp_valid_drop", resp_valid, 0);
      chk("bp_req_ready", req_ready, 1);

      // flush in WAIT, then 100 mod 7 on the same (signed) core
      r0 = resp_cnt; v0 = rv_cycles;
      issue(1'b1, 1'b0, 32'd100, 32'd3);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fw_drain_busy", busy, 1);
      chk("fw_drain_req_ready", req_ready, 0);
      issue(1'b1, 1'b1, 32'd100, 32'd7);
      wait_resp();
      chk("fw_no_early_resp", rv_cycles - v0, 0);
      chk("fw_result", resp_result, 32'h00000002);
      consume();
      chk("fw_one_resp", resp_cnt - r0, 1);

      // flush in SEND with s_tready low for 3 cycles
      s_tready = 1'b0;
      s0 = s_hs; v0 = rv_cycles;
      issue(1'b1, 1'b0, 32'd50, 32'd5);
      chk("fs_tvalid_1", s_tvalid, 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fs_tvalid_2", s_tvalid, 1);
      step();
      chk("fs_tvalid_3", s_tvalid, 1);
      s_tready = 1'b1;
      step();
      chk("fs_tvalid_drop", s_tvalid, 0);
      chk("fs_drain_req_ready", req_ready, 0);
      for (int n = 0; n < 40 && busy; n++) step();
      chk("fs_back_idle", busy, 0);
      chk("fs_no_resp", rv_cycles - v0, 0);
      chk("fs_one_hs", s_hs - s0, 1);

      // reuse pair: 100 / 7 then 100 % 7 (unsigned), then changed divisor
      u0 = u_hs;
      issue(1'b0, 1'b0, 32'd100, 32'd7);
      wait_resp();
      chk("ru_div_result", resp_result, 32'h0000000E);
      consume();
      issue(1'b0, 1'b1, 32'd100, 32'd7);
      chk("ru_fast_valid", resp_valid, REUSE);
      chk("ru_no_tvalid", u_tvalid, !REUSE);
      wait_resp();
      chk("ru_mod_result", resp_result, 32'h00000002);
      consume();
      chk("ru_u_hs", u_hs - u0, REUSE ? 1 : 2);
      u0 = u_hs;
      issue(1'b0, 1'b0, 32'd100, 32'd9);
      wait_resp();
      chk("ru_new_result", resp_result, 32'h0000000B);
      consume();
      chk("ru_new_hs", u_hs - u0, 1);

      // reset mid-operation abandons everything
      v0 = rv_cycles;
      issue(1'b0, 1'b1, 32'd100, 32'd9);
      resetn = 1'b0;
      step();
      chk("mr_busy", busy, 0);
      chk("mr_req_ready", req_ready, 1);
      chk("mr_u_tvalid", u_tvalid, 0);
      chk("mr_result", resp_result, 0);
      resetn = 1'b1;
      repeat (8) step();
      chk("mr_no_resp", rv_cycles - v0, 0);
      u0 = u_hs;
      issue(1'b0, 1'b1, 32'd100, 32'd9);
      wait_resp();
      chk("mr_after_result", resp_result, 32'h00000001);
      consume();
      chk("mr_cache_cleared_hs", u_hs - u0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
